// File: rtl/crc_pause_stack_pkg.sv
// crc_pause_stack_pkg: shared CRC key widths, stack sizing and the saved-context record
package crc_pause_stack_pkg;
  localparam int CRC_KEY_WIDTH = 4;
  localparam int CRC_KEY_SIZE  = 1 << CRC_KEY_WIDTH;
  localparam int CRC_WIDTH     = 32;
  localparam int CNT_WIDTH     = 16;
  localparam int STACK_DEPTH   = 8;
  typedef struct packed {
    logic [CRC_KEY_WIDTH-1:0] key;
    logic [CRC_WIDTH-1:0]     crc;
    logic [CNT_WIDTH-1:0]     cnt;
  } crc_ctx_t;
endpackage

// File: rtl/crc_ctx_ram.sv
// crc_ctx_ram: DEPTH x W register file, sync write / async read (MLAB-mappable); ports i_we/i_waddr/i_wdata write, i_raddr/o_rdata read
module crc_ctx_ram #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int W     = 52
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);
  logic [W-1:0] r_mem [DEPTH];
  always_ff @(posedge clk) if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/crc_pause_stack.sv
// crc_pause_stack: context stack for CRC pause/unpause; push/load/pop strobes in, TOS key, depth, restore pulse and sticky errors out
module crc_pause_stack
  import crc_pause_stack_pkg::*;
#(
  parameter int KEY_WIDTH = CRC_KEY_WIDTH,
  parameter int CRC_WIDTH = crc_pause_stack_pkg::CRC_WIDTH,
  parameter int CNT_WIDTH = crc_pause_stack_pkg::CNT_WIDTH,
  parameter int DEPTH     = STACK_DEPTH,
  parameter int PTR_WIDTH = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pause_store,
  input  logic                 unpause_load,
  input  logic                 unpause_setfsm_popstack,
  input  logic [KEY_WIDTH-1:0] cur_key,
  input  logic [CRC_WIDTH-1:0] cur_crc,
  input  logic [CNT_WIDTH-1:0] cur_cnt,
  input  logic                 clr_status,
  output logic                 empty_n,
  output logic                 full,
  output logic [KEY_WIDTH-1:0] paused_cs_tos,
  output logic                 restore_valid,
  output logic [KEY_WIDTH-1:0] restore_key,
  output logic [CRC_WIDTH-1:0] restore_crc,
  output logic [CNT_WIDTH-1:0] restore_cnt,
  output logic [PTR_WIDTH:0]   depth,
  output logic                 overflow,
  output logic                 underflow
);
  localparam int W = KEY_WIDTH + CRC_WIDTH + CNT_WIDTH;
  localparam logic [PTR_WIDTH:0] FULL_SP = (PTR_WIDTH+1)'(DEPTH);
  logic [PTR_WIDTH:0]   r_sp, w_sp_nxt;
  logic [PTR_WIDTH-1:0] w_tos_idx, w_wr_idx;
  logic [W-1:0]         w_tos;
  logic                 w_empty, w_pop_ok, w_push_ok;
  assign w_empty   = r_sp == '0;
  assign w_tos_idx = r_sp[PTR_WIDTH-1:0] - PTR_WIDTH'(1);
  assign w_pop_ok  = unpause_setfsm_popstack && !w_empty;
  // a same-cycle pop frees the TOS slot, so the push replaces it even when full
  assign w_push_ok = pause_store && (w_pop_ok || r_sp != FULL_SP);
  assign w_wr_idx  = w_pop_ok ? w_tos_idx : r_sp[PTR_WIDTH-1:0];
  always_comb begin
    w_sp_nxt = r_sp;
    w_sp_nxt = (w_push_ok && !w_pop_ok) ? r_sp + (PTR_WIDTH+1)'(1) :
               (w_pop_ok && !w_push_ok) ? r_sp - (PTR_WIDTH+1)'(1) : r_sp;
  end
  crc_ctx_ram #(.DEPTH(DEPTH), .AW(PTR_WIDTH), .W(W)) u_ram (
    .clk     (clk),
    .i_we    (w_push_ok),
    .i_waddr (w_wr_idx),
    .i_wdata ({cur_key, cur_crc, cur_cnt}),
    .i_raddr (w_tos_idx),
    .o_rdata (w_tos)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sp          <= '0;
      restore_valid <= 1'b0;
      restore_key   <= '0;
      restore_crc   <= '0;
      restore_cnt   <= '0;
      overflow      <= 1'b0;
      underflow     <= 1'b0;
    end else begin
      r_sp          <= w_sp_nxt;
      restore_valid <= unpause_load && !w_empty;
      if (unpause_load && !w_empty) {restore_key, restore_crc, restore_cnt} <= w_tos;
      overflow      <= (overflow && !clr_status) || (pause_store && !w_push_ok);
      underflow     <= (underflow && !clr_status) ||
                       ((unpause_load || unpause_setfsm_popstack) && w_empty);
    end
  end
  // flags decode straight from the registered pointer, so they track sp after every edge and clear with reset
  assign depth         = r_sp;
  assign empty_n       = !w_empty;
  assign full          = r_sp == FULL_SP;
  assign paused_cs_tos = w_empty ? '0 : w_tos[W-1 -: KEY_WIDTH];
endmodule

// File: tb/tb_crc_pause_stack.sv
// tb_crc_pause_stack: directed plus randomized checks of crc_pause_stack against a queue-based model
module tb_crc_pause_stack;
  import crc_pause_stack_pkg::*;
  logic        clk = 0, rst = 0;
  logic        pause_store = 0, unpause_load = 0, unpause_setfsm_popstack = 0, clr_status = 0;
  logic [3:0]  cur_key = 0;
  logic [31:0] cur_crc = 0;
  logic [15:0] cur_cnt = 0;
  logic        empty_n, full, restore_valid, overflow, underflow;
  logic [3:0]  paused_cs_tos, restore_key;
  logic [31:0] restore_crc;
  logic [15:0] restore_cnt;
  logic [3:0]  depth;
  int checks = 0, errors = 0;
  crc_ctx_t q[$];
  crc_ctx_t m_r;
  logic     m_rv, m_of, m_uf;
  crc_pause_stack dut (
    .clk(clk), .rst(rst), .pause_store(pause_store), .unpause_load(unpause_load),
    .unpause_setfsm_popstack(unpause_setfsm_popstack), .cur_key(cur_key), .cur_crc(cur_crc),
    .cur_cnt(cur_cnt), .clr_status(clr_status), .empty_n(empty_n), .full(full),
    .paused_cs_tos(paused_cs_tos), .restore_valid(restore_valid), .restore_key(restore_key),
    .restore_crc(restore_crc), .restore_cnt(restore_cnt), .depth(depth),
    .overflow(overflow), .underflow(underflow)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic check_all(input string tag);
    check({tag, ".depth"}, 64'(depth), 64'(q.size()));
    check({tag, ".empty_n"}, 64'(empty_n), 64'(q.size() != 0));
    check({tag, ".full"}, 64'(full), 64'(q.size() == 8));
    check({tag, ".tos"}, 64'(paused_cs_tos), q.size() != 0 ? 64'(q[$].key) : 64'd0);
    check({tag, ".rv"}, 64'(restore_valid), 64'(m_rv));
    check({tag, ".rctx"}, 64'({restore_key, restore_crc, restore_cnt}), 64'(m_r));
    check({tag, ".of"}, 64'(overflow), 64'(m_of));
    check({tag, ".uf"}, 64'(underflow), 64'(m_uf));
  endtask
  task automatic model_reset();
    q = {};
    m_r = '0;
    m_rv = 0;
    m_of = 0;
    m_uf = 0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 0;
    model_reset();
    @(negedge clk);
    rst = 1;
  endtask
  task automatic step(input string tag, input logic push, input logic pop, input logic load,
                      input logic clr, input logic [3:0] k, input logic [31:0] c, input logic [15:0] n);
    crc_ctx_t nc;
    logic of_set, uf_set;
    @(negedge clk);
    pause_store = push; unpause_setfsm_popstack = pop; unpause_load = load; clr_status = clr;
    cur_key = k; cur_crc = c; cur_cnt = n;
    @(posedge clk);
    nc = '{key: k, crc: c, cnt: n};
    of_set = 0;
    uf_set = ((load || pop) && q.size() == 0);
    m_rv = load && q.size() != 0;
    if (m_rv) m_r = q[$];
    if (push && pop && q.size() != 0) q[$] = nc;
    else if (push) begin
      if (q.size() < 8) q.push_back(nc);
      else of_set = 1;
    end else if (pop && q.size() != 0) void'(q.pop_back());
    m_of = (m_of && !clr) || of_set;
    m_uf = (m_uf && !clr) || uf_set;
    #1;
    check_all(tag);
    pause_store = 0; unpause_setfsm_popstack = 0; unpause_load = 0; clr_status = 0;
  endtask
  initial begin
    model_reset();
    #1;
    check_all("reset");
    check("reset.tos0", 64'(paused_cs_tos), 64'd0);
    do_reset();
    step("t1_push", 1, 0, 0, 0, 4'd3, 32'hDEADBEEF, 16'h0010);
    check("t1_tos3", 64'(paused_cs_tos), 64'd3);
    step("t1_load", 0, 0, 1, 0, 0, 0, 0);
    check("t1_rcrc", 64'(restore_crc), 64'hDEADBEEF);
    step("t1_idle", 0, 0, 0, 0, 0, 0, 0);
    do_reset();
    for (int i = 1; i <= 3; i++) step("t2_push", 1, 0, 0, 0, 4'(i), $urandom, 16'($urandom));
    for (int i = 0; i < 3; i++) step("t2_pop", 0, 1, 0, 0, 0, 0, 0);
    check("t2_uf0", 64'(underflow), 64'd0);
    do_reset();
    for (int i = 0; i < 8; i++) step("t3_push", 1, 0, 0, 0, 4'(i), $urandom, 16'($urandom));
    check("t3_full", 64'(full), 64'd1);
    step("t3_ovf", 1, 0, 0, 0, 4'd9, $urandom, 16'($urandom));
    check("t3_tos7", 64'(paused_cs_tos), 64'd7);
    step("t3_pushpop_full", 1, 1, 0, 0, 4'd12, $urandom, 16'($urandom));
    step("t3_load", 0, 0, 1, 0, 0, 0, 0);
    do_reset();
    step("t4_pop_empty", 0, 1, 0, 0, 0, 0, 0);
    step("t4_load_empty", 0, 0, 1, 0, 0, 0, 0);
    step("t4_clr", 0, 0, 0, 1, 0, 0, 0);
    step("t4_clr_and_set", 0, 1, 0, 1, 0, 0, 0);
    step("t4_pushpop_empty", 1, 1, 0, 1, 4'd6, 32'h1234, 16'h5);
    do_reset();
    step("t5_push1", 1, 0, 0, 0, 4'd1, 32'h11, 16'h1);
    step("t5_push2", 1, 0, 0, 0, 4'd2, 32'h22, 16'h2);
    step("t5_pushpop", 1, 1, 0, 0, 4'd5, 32'h55, 16'h5);
    check("t5_tos5", 64'(paused_cs_tos), 64'd5);
    step("t5_load", 0, 0, 1, 0, 0, 0, 0);
    step("t5_loadpop", 0, 1, 1, 0, 0, 0, 0);
    step("t5_loadpush", 1, 0, 1, 0, 4'd8, 32'h88, 16'h8);
    for (int i = 0; i < 3; i++) step("t6_push", 1, 0, 0, 0, 4'(i + 4), $urandom, 16'($urandom));
    step("t6_load", 0, 0, 1, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    rst = 0;
    model_reset();
    #1;
    check("t6_async_depth", 64'(depth), 64'd0);
    check("t6_async_empty_n", 64'(empty_n), 64'd0);
    check("t6_async_tos", 64'(paused_cs_tos), 64'd0);
    check("t6_async_rkey", 64'(restore_key), 64'd0);
    check_all("t6_async");
    @(negedge clk);
    rst = 1;
    step("t6_load_after", 0, 0, 1, 0, 0, 0, 0);
    check("t6_uf", 64'(underflow), 64'd1);
    for (int i = 0; i < 400; i++)
      step("rand", $urandom_range(0, 9) < 5, $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3,
           $urandom_range(0, 9) == 0, 4'($urandom), $urandom, 16'($urandom));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
